// File: rtl/dtw_core_ctrl_if.sv
// Host-side bundle for dtw_core_ctrl: query/reference sample streams and the
// result handshake. The master drives samples and consumes results.
interface dtw_core_ctrl_if #(
  parameter int unsigned width = 16
);
  logic [width-1:0] sqg_data;
  logic             sqg_valid;
  logic             sqg_ready;

  logic [width-1:0] ref_data;
  logic             ref_valid;
  logic             ref_ready;

  logic             res_valid;
  logic             res_ready;
  logic [width-1:0] res_minval;
  logic [31:0]      res_position;
  logic             res_hit;
  logic [31:0]      res_cycles;

  modport master (
    output sqg_data, sqg_valid, ref_data, ref_valid, res_ready,
    input  sqg_ready, ref_ready, res_valid, res_minval, res_position,
           res_hit, res_cycles
  );

  modport slave (
    input  sqg_data, sqg_valid, ref_data, ref_valid, res_ready,
    output sqg_ready, ref_ready, res_valid, res_minval, res_position,
           res_hit, res_cycles
  );
endinterface

// File: rtl/dtw_core_ctrl.sv
// Job sequencer for the subsequence-DTW systolic datapath: streams one query
// and one reference, stalls on starvation, and returns min cost/position/hit.
module dtw_core_ctrl #(
  parameter int unsigned width    = 16,
  parameter int unsigned SQG_SIZE = 250
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      cfg_ref_len,
  input  logic [width-1:0] cfg_thresh,
  input  logic             abort,
  output logic             busy,
  output logic             err,
  dtw_core_ctrl_if.slave   bus,
  output logic             dp_rst,
  output logic             dp_running,
  output logic [width-1:0] dp_squiggle,
  output logic [width-1:0] dp_rword,
  output logic [31:0]      dp_ref_len,
  input  logic [width-1:0] dp_minval,
  input  logic [31:0]      dp_position,
  input  logic             dp_done
);

  localparam int unsigned      SQG_W    = $clog2(SQG_SIZE + 1);
  localparam logic [SQG_W-1:0] SQG_LAST = SQG_W'(SQG_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PRIME,
    S_RUN,
    S_DRAIN,
    S_RESULT
  } state_e;

  state_e           state_q, state_d;
  logic             abort_pend_q, abort_pend_d;
  logic             rst_hold_q;
  logic             err_q, err_d;
  logic [31:0]      ref_len_q, ref_len_d;
  logic [width-1:0] thresh_q, thresh_d;
  logic [SQG_W-1:0] sqg_cnt_q, sqg_cnt_d;
  logic [31:0]      ref_cnt_q, ref_cnt_d;
  logic [31:0]      cyc_q, cyc_d;
  logic             drain_q, drain_d;
  logic [width-1:0] res_minval_q, res_minval_d;
  logic [31:0]      res_position_q, res_position_d;
  logic             res_hit_q, res_hit_d;
  logic [31:0]      res_cycles_q, res_cycles_d;

  logic sqg_more, ref_more, sqg_ok, ref_ok;
  logic run_en, sqg_rdy, ref_rdy, res_vld;

  always_comb begin
    state_d        = state_q;
    abort_pend_d   = abort_pend_q;
    err_d          = err_q;
    ref_len_d      = ref_len_q;
    thresh_d       = thresh_q;
    sqg_cnt_d      = sqg_cnt_q;
    ref_cnt_d      = ref_cnt_q;
    cyc_d          = cyc_q;
    drain_d        = drain_q;
    res_minval_d   = res_minval_q;
    res_position_d = res_position_q;
    res_hit_d      = res_hit_q;
    res_cycles_d   = res_cycles_q;
    run_en         = 1'b0;
    sqg_rdy        = 1'b0;
    ref_rdy        = 1'b0;
    res_vld        = 1'b0;

    sqg_more = sqg_cnt_q < SQG_LAST;
    ref_more = ref_cnt_q < ref_len_q;
    sqg_ok   = (sqg_cnt_q == SQG_LAST) | bus.sqg_valid;
    ref_ok   = (ref_cnt_q == ref_len_q) | bus.ref_valid;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ref_len == '0) begin
            err_d = 1'b1;
          end else begin
            state_d      = S_CLEAR;
            abort_pend_d = 1'b0;
            err_d        = 1'b0;
            ref_len_d    = cfg_ref_len;
            thresh_d     = cfg_thresh;
            sqg_cnt_d    = '0;
            ref_cnt_d    = '0;
            cyc_d        = '0;
            drain_d      = 1'b0;
          end
        end
      end
      S_CLEAR: begin
        // The same clear state serves a fresh job and the abort clean-up.
        state_d      = abort_pend_q ? S_IDLE : S_PRIME;
        abort_pend_d = 1'b0;
      end
      S_PRIME: begin
        run_en  = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        cyc_d   = cyc_q + 32'd1;
        run_en  = sqg_ok & ref_ok & ~dp_done;
        sqg_rdy = run_en & sqg_more;
        ref_rdy = run_en & ref_more;
        if (sqg_rdy && bus.sqg_valid) sqg_cnt_d = sqg_cnt_q + SQG_W'(1);
        if (ref_rdy && bus.ref_valid) ref_cnt_d = ref_cnt_q + 32'd1;
        if (dp_done) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          res_minval_d   = dp_minval;
          res_position_d = dp_position;
          res_hit_d      = dp_minval < thresh_q;
          res_cycles_d   = cyc_q;
          state_d        = S_RESULT;
        end
      end
      S_RESULT: begin
        res_vld = 1'b1;
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort outranks everything: freeze streams, hide the result, discard capture.
    if (abort && state_q != S_IDLE) begin
      state_d        = S_CLEAR;
      abort_pend_d   = 1'b1;
      run_en         = 1'b0;
      sqg_rdy        = 1'b0;
      ref_rdy        = 1'b0;
      res_vld        = 1'b0;
      sqg_cnt_d      = sqg_cnt_q;
      ref_cnt_d      = ref_cnt_q;
      res_minval_d   = res_minval_q;
      res_position_d = res_position_q;
      res_hit_d      = res_hit_q;
      res_cycles_d   = res_cycles_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      abort_pend_q   <= 1'b0;
      rst_hold_q     <= 1'b1;
      err_q          <= 1'b0;
      ref_len_q      <= '0;
      thresh_q       <= '0;
      sqg_cnt_q      <= '0;
      ref_cnt_q      <= '0;
      cyc_q          <= '0;
      drain_q        <= 1'b0;
      res_minval_q   <= '0;
      res_position_q <= '0;
      res_hit_q      <= 1'b0;
      res_cycles_q   <= '0;
    end else begin
      state_q        <= state_d;
      abort_pend_q   <= abort_pend_d;
      rst_hold_q     <= 1'b0;
      err_q          <= err_d;
      ref_len_q      <= ref_len_d;
      thresh_q       <= thresh_d;
      sqg_cnt_q      <= sqg_cnt_d;
      ref_cnt_q      <= ref_cnt_d;
      cyc_q          <= cyc_d;
      drain_q        <= drain_d;
      res_minval_q   <= res_minval_d;
      res_position_q <= res_position_d;
      res_hit_q      <= res_hit_d;
      res_cycles_q   <= res_cycles_d;
    end
  end

  assign busy             = state_q != S_IDLE;
  assign err              = err_q;
  assign dp_rst           = rst_hold_q | (state_q == S_CLEAR);
  assign dp_running       = run_en;
  assign dp_squiggle      = bus.sqg_data;
  // Past the end of the reference the datapath is flushed with zeros.
  assign dp_rword         = ref_more ? bus.ref_data : '0;
  assign dp_ref_len       = ref_len_q;
  assign bus.sqg_ready    = sqg_rdy;
  assign bus.ref_ready    = ref_rdy;
  assign bus.res_valid    = res_vld;
  assign bus.res_minval   = res_minval_q;
  assign bus.res_position = res_position_q;
  assign bus.res_hit      = res_hit_q;
  assign bus.res_cycles   = res_cycles_q;

endmodule

// File: tb/tb_dtw_core_ctrl.sv
// Bench for dtw_core_ctrl with a small behavioural datapath stand-in that
// records streamed samples and reports a sliding-window absolute-difference minimum.
module tb_dtw_core_ctrl;

  localparam int unsigned SQG  = 4;
  localparam int unsigned RMAX = 32;

  typedef logic [15:0] qarr_t [SQG];
  typedef logic [15:0] rarr_t [RMAX];
  typedef struct {
    logic [15:0] minval;
    logic [31:0] pos;
    logic        hit;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] cfg_ref_len;
  logic [15:0] cfg_thresh;
  logic        abort;
  logic        busy;
  logic        err;
  logic        dp_rst;
  logic        dp_running;
  logic [15:0] dp_squiggle;
  logic [15:0] dp_rword;
  logic [31:0] dp_ref_len;
  logic [15:0] dp_minval   = '0;
  logic [31:0] dp_position = '0;
  logic        m_done      = 1'b0;

  dtw_core_ctrl_if #(.width(16)) bus ();

  dtw_core_ctrl #(.width(16), .SQG_SIZE(SQG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_ref_len (cfg_ref_len),
    .cfg_thresh  (cfg_thresh),
    .abort       (abort),
    .busy        (busy),
    .err         (err),
    .bus         (bus),
    .dp_rst      (dp_rst),
    .dp_running  (dp_running),
    .dp_squiggle (dp_squiggle),
    .dp_rword    (dp_rword),
    .dp_ref_len  (dp_ref_len),
    .dp_minval   (dp_minval),
    .dp_position (dp_position),
    .dp_done     (m_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void golden(input qarr_t q, input rarr_t r, input int unsigned len,
                                 output logic [15:0] mv, output logic [31:0] mp);
    int unsigned best, cost, a, b;
    best = 32'hFFFF;
    mp   = '0;
    for (int unsigned j = SQG - 1; j < len; j++) begin
      cost = 0;
      for (int unsigned i = 0; i < SQG; i++) begin
        a = q[i];
        b = r[j - SQG + 1 + i];
        cost += (a > b) ? a - b : b - a;
      end
      if (cost < best) begin
        best = cost;
        mp   = j;
      end
    end
    mv = 16'(best);
  endfunction

  // Datapath stand-in: running cycle 0 is the prime cycle, 1..N carry samples.
  logic [31:0] m_run     = '0;
  logic        m_res_don = 1'b0;
  int          m_pad_bad = 0;
  qarr_t       m_q;
  rarr_t       m_r;

  always @(posedge clk) begin
    logic [15:0] mv;
    logic [31:0] mp;
    if (dp_rst) begin
      m_run     <= '0;
      m_done    <= 1'b0;
      m_res_don <= 1'b0;
    end else begin
      if (dp_running) begin
        if (m_run >= 1 && m_run <= SQG) m_q[m_run - 1] <= dp_squiggle;
        if (m_run >= 1 && m_run <= dp_ref_len) m_r[m_run - 1] <= dp_rword;
        else if (m_run > dp_ref_len && dp_rword != '0) m_pad_bad <= m_pad_bad + 1;
        m_run <= m_run + 1;
        if (m_run + 1 == dp_ref_len + SQG + 1) m_done <= 1'b1;
      end
      if (m_done && !m_res_don) begin
        golden(m_q, m_r, dp_ref_len, mv, mp);
        dp_minval   <= mv;
        dp_position <= mp;
        m_res_don   <= 1'b1;
      end
    end
  end

  logic [15:0] sq_q[$];
  logic [15:0] rf_q[$];
  exp_t        sb[$];
  int unsigned stall_pct = 0;
  int edge_n = 0, first_hs = 0, cap_edge = 0, valid_cycles = 0, ref_hs = 0, viol = 0;
  int last_acc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    bus.sqg_valid = 1'b0;
    bus.sqg_data  = '0;
    forever begin
      @(negedge clk);
      if (sq_q.size() > 0 && $urandom_range(99) >= stall_pct) begin
        bus.sqg_valid = 1'b1;
        bus.sqg_data  = sq_q[0];
      end else begin
        bus.sqg_valid = 1'b0;
        bus.sqg_data  = 16'($urandom);
      end
    end
  end

  initial begin
    bus.ref_valid = 1'b0;
    bus.ref_data  = '0;
    forever begin
      @(negedge clk);
      if (rf_q.size() > 0 && $urandom_range(99) >= stall_pct) begin
        bus.ref_valid = 1'b1;
        bus.ref_data  = rf_q[0];
      end else begin
        bus.ref_valid = 1'b0;
        bus.ref_data  = 16'($urandom);
      end
    end
  end

  // Handshake, timing and scoreboard monitor (sees values held through the cycle).
  always @(posedge clk) begin
    exp_t e;
    edge_n++;
    if (bus.sqg_valid && bus.sqg_ready) begin
      if (!dp_running) viol++;
      if (first_hs == 0) first_hs = edge_n;
      if (sq_q.size() > 0) void'(sq_q.pop_front());
    end
    if (bus.ref_valid && bus.ref_ready) begin
      if (!dp_running) viol++;
      if (first_hs == 0) first_hs = edge_n;
      ref_hs++;
      if (rf_q.size() > 0) void'(rf_q.pop_front());
    end
    if (bus.res_valid) begin
      valid_cycles++;
      if (cap_edge == 0) cap_edge = edge_n - 1;
    end
    if (bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        check("res_minval", bus.res_minval, e.minval);
        check("res_position", bus.res_position, e.pos);
        check("res_hit", bus.res_hit, e.hit);
        check("res_cycles", bus.res_cycles, 64'(cap_edge - e.acc - 4));
      end
    end
  end

  task automatic run_job(input qarr_t q, input rarr_t r, input int unsigned len,
                         input logic [15:0] thr, input int unsigned stall, input bit want);
    exp_t e;
    stall_pct = stall;
    sq_q.delete();
    rf_q.delete();
    for (int unsigned i = 0; i < SQG; i++) sq_q.push_back(q[i]);
    for (int unsigned i = 0; i < len; i++) rf_q.push_back(r[i]);
    first_hs = 0; cap_edge = 0; valid_cycles = 0; ref_hs = 0;
    @(negedge clk);
    cfg_ref_len = len;
    cfg_thresh  = thr;
    start       = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    last_acc = edge_n;
    if (want) begin
      golden(q, r, len, e.minval, e.pos);
      e.hit = e.minval < thr;
      e.acc = edge_n;
      sb.push_back(e);
    end
  endtask

  task automatic wait_results();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  qarr_t qa = '{16'd5, 16'd6, 16'd7, 16'd8};
  rarr_t ra = '{0:16'd1, 1:16'd5, 2:16'd6, 3:16'd7, 4:16'd8, 5:16'd2, default:16'd0};
  qarr_t qb = '{16'd10, 16'd20, 16'd30, 16'd40};
  rarr_t rb = '{0:16'd11, 1:16'd22, 2:16'd29, 3:16'd41, 4:16'd3, 5:16'd9,
                6:16'd12, 7:16'd19, 8:16'd33, 9:16'd38, default:16'd0};

  initial begin
    int n, rst_seen, busy_seen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_ref_len = '0; cfg_thresh = '0; bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_dp_rst", dp_rst, 1);
    check("rst_running", dp_running, 0);
    check("rst_rdy", {bus.sqg_ready, bus.ref_ready, bus.res_valid}, 0);
    check("rst_res", {bus.res_minval, bus.res_position, bus.res_hit, bus.res_cycles}, 0);
    check("rst_ref_len", dp_ref_len, 0);
    rst_n = 1'b1;
    #1 check("dp_rst_hold", dp_rst, 1);
    @(negedge clk);
    check("dp_rst_release", dp_rst, 0);

    // Exact match, no stalls.
    run_job(qa, ra, 6, 16'd1, 0, 1'b1);
    wait_results();
    check("first_hs_latency", first_hs - last_acc, 3);
    check("job_length", cap_edge - last_acc, 4 + 6 + SQG + 1);
    check("res_valid_cycles", valid_cycles, 1);
    check("busy_after_job", busy, 0);

    // Same job under random starvation of both streams.
    run_job(qa, ra, 6, 16'd1, 30, 1'b1);
    wait_results();
    check("stall_busy_after", busy, 0);

    // Hit threshold equal to the minimum must not report a hit.
    run_job(qb, rb, 10, 16'd5, 0, 1'b1);
    wait_results();

    // Zero-length start.
    @(negedge clk);
    cfg_ref_len = '0;
    start = 1'b1;
    rst_seen = 0; busy_seen = 0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      if (dp_rst) rst_seen++;
      if (busy) busy_seen++;
      @(negedge clk);
    end
    check("zero_len_err", err, 1);
    check("zero_len_busy", busy_seen, 0);
    check("zero_len_dp_rst", rst_seen, 0);
    run_job(qb, rb, 10, 16'd9, 0, 1'b1);
    check("err_cleared", err, 0);
    wait_results();

    // Abort after three reference samples.
    run_job(qb, rb, 10, 16'd9, 0, 1'b0);
    n = 0;
    while (ref_hs < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_3", ref_hs, 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_dp_rst", dp_rst, 1);
    check("abort_no_extra_hs", ref_hs, 3);
    sq_q.delete();
    rf_q.delete();
    @(negedge clk);
    check("abort_dp_rst_end", dp_rst, 0);
    check("abort_idle", busy, 0);
    repeat (5) @(negedge clk);
    check("abort_no_result", valid_cycles, 0);
    run_job(qa, ra, 6, 16'd1, 0, 1'b1);
    wait_results();

    // Result backpressure with ignored start pulses.
    bus.res_ready = 1'b0;
    run_job(qb, rb, 10, 16'd6, 0, 1'b1);
    n = 0;
    while (!bus.res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int unsigned i = 0; i < 10; i++) begin
      check("bp_valid", bus.res_valid, 1);
      check("bp_minval", bus.res_minval, (sb.size() > 0) ? sb[0].minval : 16'hDEAD);
      check("bp_busy", busy, 1);
      cfg_ref_len = 6;
      start = i[0];
      @(negedge clk);
    end
    start = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("bp_released_idle", busy, 0);
    check("bp_sb_empty", sb.size(), 0);

    // Asynchronous reset in the middle of RUN.
    run_job(qb, rb, 10, 16'd9, 0, 1'b0);
    n = 0;
    while (ref_hs < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_dp_rst", dp_rst, 1);
    check("arst_running", dp_running, 0);
    check("arst_rdy", {bus.sqg_ready, bus.ref_ready, bus.res_valid}, 0);
    check("arst_res", {bus.res_minval, bus.res_position, bus.res_hit, bus.res_cycles}, 0);
    check("arst_ref_len", dp_ref_len, 0);
    sq_q.delete();
    rf_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_release_busy", busy, 0);

    check("handshake_while_stalled", viol, 0);
    check("zero_padding", m_pad_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
